// File: rtl/ddr2_cmd_executor.sv
// ---------------------------------------------------------------------------
// ddr2_cmd_executor
//
// Turns the 3-bit command codes from the init sequencer / command mux into
// registered DDR2 control pins, then holds NOP for the spacing that the
// command requires before it accepts another one. The ready/valid handshake
// keeps upstream from issuing faster than DDR2 timing allows.
//
// Timing of one command with spacing T_x:
//   edge N      : command accepted; pins load the command; ready drops
//   edge N+1    : pins return to NOP
//   edge N+T_x-1: ready rises and done pulses
//   edge N+T_x  : earliest next accept, so pin-to-pin spacing is exactly T_x
//
// Ports:
//   CLK_in        system clock, rising edge
//   RST_in        asynchronous active-high reset
//   CMD_in        000 NOP, 001 LOAD MODE, 010 PRECHARGE ALL, 011 AUTO REFRESH,
//                 100 ACTIVATE, 101 READ, 110 WRITE, 111 reserved
//   CMD_VALID_in  CMD_in / BA_in / ADDR_in valid this cycle
//   BA_in         bank address (mode-register select for LOAD MODE)
//   ADDR_in       row, column or mode value
//   CMD_READY_out executor accepts a command this cycle
//   CS_N_out, RAS_N_out, CAS_N_out, WE_N_out  DDR2 command pins
//   BA_out, A_out DDR2 bank and address pins
//   CMD_DONE_out  one-cycle pulse when a command's spacing has expired
//   CMD_ERR_out   sticky; set when a reserved code is accepted
// ---------------------------------------------------------------------------
module ddr2_cmd_executor #(
   parameter int unsigned T_MRD = 2,
   parameter int unsigned T_RP  = 4,
   parameter int unsigned T_RFC = 26,
   parameter int unsigned T_RCD = 4,
   parameter int unsigned T_RD  = 2,
   parameter int unsigned T_WR  = 6
) (
   input  logic        CLK_in,
   input  logic        RST_in,
   input  logic [2:0]  CMD_in,
   input  logic        CMD_VALID_in,
   input  logic [1:0]  BA_in,
   input  logic [12:0] ADDR_in,
   output logic        CMD_READY_out,
   output logic        CS_N_out,
   output logic        RAS_N_out,
   output logic        CAS_N_out,
   output logic        WE_N_out,
   output logic [1:0]  BA_out,
   output logic [12:0] A_out,
   output logic        CMD_DONE_out,
   output logic        CMD_ERR_out
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned T_MAX =
      max2(max2(max2(T_MRD, T_RP), max2(T_RFC, T_RCD)), max2(T_RD, T_WR));
   localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

   // {CS_N, RAS_N, CAS_N, WE_N}
   localparam logic [3:0] PINS_NOP      = 4'b0111;
   localparam logic [3:0] PINS_DESELECT = 4'b1111;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] count_q;
   logic [3:0]       pins_q;
   logic [1:0]       ba_q;
   logic [12:0]      a_q;
   logic             ready_q;
   logic             done_q;
   logic             err_q;

   // Decode of the incoming code: pin pattern, wait-counter preload, and
   // whether it is a real command that occupies the bus.
   logic [3:0]       cmd_pins;
   logic [CNT_W-1:0] cmd_load;
   logic             cmd_real;
   logic [12:0]      cmd_addr;
   logic             accept;

   always_comb begin
      cmd_pins = PINS_NOP;
      cmd_load = '0;
      cmd_real = 1'b1;
      cmd_addr = ADDR_in;
      case (CMD_in)
         3'b001: begin
            cmd_pins = 4'b0000;
            cmd_load = CNT_W'(T_MRD - 2);
         end
         3'b010: begin
            cmd_pins    = 4'b0010;
            cmd_load    = CNT_W'(T_RP - 2);
            cmd_addr[10] = 1'b1;  // A10 high selects "all banks"
         end
         3'b011: begin
            cmd_pins = 4'b0001;
            cmd_load = CNT_W'(T_RFC - 2);
         end
         3'b100: begin
            cmd_pins = 4'b0011;
            cmd_load = CNT_W'(T_RCD - 2);
         end
         3'b101: begin
            cmd_pins = 4'b0101;
            cmd_load = CNT_W'(T_RD - 2);
         end
         3'b110: begin
            cmd_pins = 4'b0100;
            cmd_load = CNT_W'(T_WR - 2);
         end
         default: begin
            // 000 NOP and 111 reserved: nothing reaches the pins
            cmd_real = 1'b0;
         end
      endcase
   end

   assign accept = CMD_VALID_in & ready_q;

   always_ff @(posedge CLK_in or posedge RST_in) begin
      if (RST_in) begin
         state_q <= StIdle;
         count_q <= '0;
         pins_q  <= PINS_DESELECT;
         ba_q    <= 2'b00;
         a_q     <= 13'h0000;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               pins_q <= PINS_NOP;
               if (accept) begin
                  if (cmd_real) begin
                     pins_q  <= cmd_pins;
                     ba_q    <= BA_in;
                     a_q     <= cmd_addr;
                     count_q <= cmd_load;
                     ready_q <= 1'b0;
                     state_q <= StIssue;
                  end else begin
                     // No bus occupancy, so completion is reported at once
                     done_q <= 1'b1;
                     if (CMD_in == 3'b111) begin
                        err_q <= 1'b1;
                     end
                  end
               end
            end
            StIssue, StWait: begin
               // BA/A keep the last command's values while the bus idles
               pins_q <= PINS_NOP;
               if (count_q == '0) begin
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  count_q <= count_q - 1'b1;
                  state_q <= StWait;
               end
            end
            default: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign CMD_READY_out = ready_q;
   assign CS_N_out      = pins_q[3];
   assign RAS_N_out     = pins_q[2];
   assign CAS_N_out     = pins_q[1];
   assign WE_N_out      = pins_q[0];
   assign BA_out        = ba_q;
   assign A_out         = a_q;
   assign CMD_DONE_out  = done_q;
   assign CMD_ERR_out   = err_q;

endmodule

// File: tb/tb_ddr2_cmd_executor.sv
module tb_ddr2_cmd_executor;

   logic        CLK_in;
   logic        RST_in;
   logic [2:0]  CMD_in;
   logic        CMD_VALID_in;
   logic [1:0]  BA_in;
   logic [12:0] ADDR_in;
   logic        CMD_READY_out;
   logic        CS_N_out;
   logic        RAS_N_out;
   logic        CAS_N_out;
   logic        WE_N_out;
   logic [1:0]  BA_out;
   logic [12:0] A_out;
   logic        CMD_DONE_out;
   logic        CMD_ERR_out;

   int vectors;
   int miscompares;

   logic [3:0] pins;
   assign pins = {CS_N_out, RAS_N_out, CAS_N_out, WE_N_out};

   ddr2_cmd_executor dut (
      .CLK_in        (CLK_in),
      .RST_in        (RST_in),
      .CMD_in        (CMD_in),
      .CMD_VALID_in  (CMD_VALID_in),
      .BA_in         (BA_in),
      .ADDR_in       (ADDR_in),
      .CMD_READY_out (CMD_READY_out),
      .CS_N_out      (CS_N_out),
      .RAS_N_out     (RAS_N_out),
      .CAS_N_out     (CAS_N_out),
      .WE_N_out      (WE_N_out),
      .BA_out        (BA_out),
      .A_out         (A_out),
      .CMD_DONE_out  (CMD_DONE_out),
      .CMD_ERR_out   (CMD_ERR_out)
   );

   initial begin
      CLK_in = 1'b0;
      forever #5 CLK_in = ~CLK_in;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1);
   end

   // Inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(negedge CLK_in);
   endtask

   task automatic test_reset();
      RST_in = 1'b0; CMD_VALID_in = 1'b0; CMD_in = 3'b000; BA_in = 2'b00; ADDR_in = '0;
      step(); step();
      #2 RST_in = 1'b1;
      #1;
      vectors++;
      if (pins !== 4'b1111) begin
         miscompares++; $display("FAIL reset_pins: got %b want 1111", pins);
      end
      vectors++;
      if (CMD_READY_out !== 1'b1 || CMD_ERR_out !== 1'b0 || CMD_DONE_out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got rdy=%b err=%b done=%b want 1 0 0",
                  CMD_READY_out, CMD_ERR_out, CMD_DONE_out);
      end
      vectors++;
      if (BA_out !== 2'b00 || A_out !== 13'h0000) begin
         miscompares++; $display("FAIL reset_addr: got ba=%h a=%h want 0 0", BA_out, A_out);
      end
      step();
      RST_in = 1'b0;
      step();
      vectors++;
      if (pins !== 4'b0111 || CMD_READY_out !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_nop: got pins=%b rdy=%b want 0111 1", pins, CMD_READY_out);
      end
   endtask

   task automatic test_precharge();
      CMD_in = 3'b010; BA_in = 2'b11; ADDR_in = 13'h0000; CMD_VALID_in = 1'b1;
      step();  // after edge N
      CMD_VALID_in = 1'b0;
      vectors++;
      if (pins !== 4'b0010 || A_out !== 13'h0400 || BA_out !== 2'b11) begin
         miscompares++;
         $display("FAIL pre_issue: got pins=%b a=%h ba=%b want 0010 0400 11", pins, A_out, BA_out);
      end
      vectors++;
      if (CMD_READY_out !== 1'b0) begin
         miscompares++; $display("FAIL pre_rdy_n: got %b want 0", CMD_READY_out);
      end
      step();  // after N+1
      vectors++;
      if (pins !== 4'b0111 || CMD_READY_out !== 1'b0 || A_out !== 13'h0400) begin
         miscompares++;
         $display("FAIL pre_wait1: got pins=%b rdy=%b a=%h want 0111 0 0400",
                  pins, CMD_READY_out, A_out);
      end
      step();  // after N+2
      vectors++;
      if (CMD_READY_out !== 1'b0 || CMD_DONE_out !== 1'b0) begin
         miscompares++;
         $display("FAIL pre_wait2: got rdy=%b done=%b want 0 0", CMD_READY_out, CMD_DONE_out);
      end
      step();  // after N+3
      vectors++;
      if (CMD_READY_out !== 1'b1 || CMD_DONE_out !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_done: got rdy=%b done=%b want 1 1", CMD_READY_out, CMD_DONE_out);
      end
      // Accept at N+4: a READ must appear right after
      CMD_in = 3'b101; BA_in = 2'b10; ADDR_in = 13'h0010; CMD_VALID_in = 1'b1;
      step();
      CMD_VALID_in = 1'b0;
      vectors++;
      if (pins !== 4'b0101 || CMD_DONE_out !== 1'b0 || A_out !== 13'h0010) begin
         miscompares++;
         $display("FAIL pre_next: got pins=%b done=%b a=%h want 0101 0 0010",
                  pins, CMD_DONE_out, A_out);
      end
      step();  // READ spacing 2 completes
   endtask

   task automatic test_back_to_back();
      int cyc;
      int dones;
      logic seen;
      CMD_in = 3'b011; BA_in = 2'b00; ADDR_in = 13'h0000; CMD_VALID_in = 1'b1;
      step();
      vectors++;
      if (pins !== 4'b0001) begin
         miscompares++; $display("FAIL ref_issue: got %b want 0001", pins);
      end
      CMD_in = 3'b100; BA_in = 2'b10; ADDR_in = 13'h0123;
      cyc = 0; dones = 0; seen = 1'b0;
      while (!seen && cyc < 40) begin
         step();
         cyc++;
         if (CMD_DONE_out === 1'b1) dones++;
         if (pins === 4'b0011) seen = 1'b1;
      end
      CMD_VALID_in = 1'b0;
      vectors++;
      if (!seen || cyc != 26) begin
         miscompares++;
         $display("FAIL ref_act_gap: got seen=%b gap=%0d want 1 26", seen, cyc);
      end
      vectors++;
      if (dones != 1) begin
         miscompares++; $display("FAIL ref_done_cnt: got %0d want 1", dones);
      end
      vectors++;
      if (BA_out !== 2'b10 || A_out !== 13'h0123) begin
         miscompares++; $display("FAIL act_addr: got ba=%b a=%h want 10 0123", BA_out, A_out);
      end
      repeat (3) step();
      vectors++;
      if (CMD_READY_out !== 1'b1) begin
         miscompares++; $display("FAIL act_ready: got %b want 1", CMD_READY_out);
      end
   endtask

   task automatic test_load_mode();
      CMD_in = 3'b001; BA_in = 2'b01; ADDR_in = 13'h0044; CMD_VALID_in = 1'b1;
      step();
      CMD_VALID_in = 1'b0;
      vectors++;
      if (pins !== 4'b0000 || BA_out !== 2'b01 || A_out !== 13'h0044 || CMD_READY_out !== 1'b0) begin
         miscompares++;
         $display("FAIL lmr_issue: got pins=%b ba=%b a=%h rdy=%b want 0000 01 0044 0",
                  pins, BA_out, A_out, CMD_READY_out);
      end
      step();
      vectors++;
      if (CMD_READY_out !== 1'b1 || CMD_DONE_out !== 1'b1 || pins !== 4'b0111) begin
         miscompares++;
         $display("FAIL lmr_done: got rdy=%b done=%b pins=%b want 1 1 0111",
                  CMD_READY_out, CMD_DONE_out, pins);
      end
   endtask

   task automatic test_reserved();
      CMD_in = 3'b000; CMD_VALID_in = 1'b1;
      step();
      vectors++;
      if (pins !== 4'b0111 || CMD_DONE_out !== 1'b1 || CMD_ERR_out !== 1'b0 ||
          CMD_READY_out !== 1'b1) begin
         miscompares++;
         $display("FAIL nop_acc: got pins=%b done=%b err=%b rdy=%b want 0111 1 0 1",
                  pins, CMD_DONE_out, CMD_ERR_out, CMD_READY_out);
      end
      CMD_in = 3'b111;
      step();
      vectors++;
      if (pins !== 4'b0111 || CMD_ERR_out !== 1'b1 || CMD_DONE_out !== 1'b1 ||
          CMD_READY_out !== 1'b1) begin
         miscompares++;
         $display("FAIL rsv_acc: got pins=%b err=%b done=%b rdy=%b want 0111 1 1 1",
                  pins, CMD_ERR_out, CMD_DONE_out, CMD_READY_out);
      end
      CMD_in = 3'b101; BA_in = 2'b00; ADDR_in = 13'h0008;
      step();
      CMD_VALID_in = 1'b0;
      vectors++;
      if (pins !== 4'b0101 || CMD_ERR_out !== 1'b1 || A_out !== 13'h0008) begin
         miscompares++;
         $display("FAIL rsv_read: got pins=%b err=%b a=%h want 0101 1 0008",
                  pins, CMD_ERR_out, A_out);
      end
      step();
      vectors++;
      if (CMD_READY_out !== 1'b1 || CMD_ERR_out !== 1'b1) begin
         miscompares++;
         $display("FAIL rsv_sticky: got rdy=%b err=%b want 1 1", CMD_READY_out, CMD_ERR_out);
      end
   endtask

   task automatic test_reset_mid_wait();
      CMD_in = 3'b110; BA_in = 2'b11; ADDR_in = 13'h0abc; CMD_VALID_in = 1'b1;
      step();
      CMD_VALID_in = 1'b0;
      vectors++;
      if (pins !== 4'b0100 || CMD_READY_out !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_issue: got pins=%b rdy=%b want 0100 0", pins, CMD_READY_out);
      end
      step();
      RST_in = 1'b1;
      #1;
      vectors++;
      if (pins !== 4'b1111 || CMD_READY_out !== 1'b1 || CMD_ERR_out !== 1'b0 ||
          BA_out !== 2'b00 || A_out !== 13'h0000) begin
         miscompares++;
         $display("FAIL wr_reset: got pins=%b rdy=%b err=%b ba=%b a=%h want 1111 1 0 00 0000",
                  pins, CMD_READY_out, CMD_ERR_out, BA_out, A_out);
      end
      step();
      RST_in = 1'b0;
      CMD_in = 3'b100; BA_in = 2'b01; ADDR_in = 13'h0555; CMD_VALID_in = 1'b1;
      step();
      CMD_VALID_in = 1'b0;
      vectors++;
      if (pins !== 4'b0011 || A_out !== 13'h0555 || BA_out !== 2'b01) begin
         miscompares++;
         $display("FAIL post_reset_act: got pins=%b a=%h ba=%b want 0011 0555 01",
                  pins, A_out, BA_out);
      end
      repeat (4) step();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_precharge();
      test_back_to_back();
      test_load_mode();
      test_reserved();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ddr2_cmd_executor.md
Name: ddr2_cmd_executor

Overview:
Consumes the 3-bit command code stream produced by the DDR2 init sequencer and command mux. Translates each code into registered DDR2 control pins (CS#, RAS#, CAS#, WE#, BA, A), then holds NOP for the JEDEC spacing that command requires. Exposes a ready/valid handshake so the upstream sequencer cannot issue faster than DDR2 timing allows. Sits between the command mux and the DDR2 pad ring.

Parameters:
T_MRD, 2, cycles from LOAD MODE to next command (min 2)
T_RP, 4, cycles from PRECHARGE ALL to next command (min 2)
T_RFC, 26, cycles from AUTO REFRESH to next command (min 2)
T_RCD, 4, cycles from ACTIVATE to next command (min 2)
T_RD, 2, cycles from READ to next command (min 2)
T_WR, 6, cycles from WRITE to next command (min 2)

Ports:
CLK_in  input  1  system clock; all state updates on posedge
RST_in  input  1  asynchronous, active-high reset
CMD_in  input  3  command code: 000 NOP, 001 LOAD MODE, 010 PRECHARGE ALL, 011 AUTO REFRESH, 100 ACTIVATE, 101 READ, 110 WRITE, 111 reserved
CMD_VALID_in  input  1  CMD_in, BA_in and ADDR_in are valid this cycle
BA_in  input  2  bank address; mode-register select for LOAD MODE
ADDR_in  input  13  row, column or mode value
CMD_READY_out  output  1  executor can accept a command this cycle
CS_N_out  output  1  DDR2 chip select, active low
RAS_N_out  output  1  DDR2 RAS#
CAS_N_out  output  1  DDR2 CAS#
WE_N_out  output  1  DDR2 WE#
BA_out  output  2  DDR2 bank address
A_out  output  13  DDR2 address
CMD_DONE_out  output  1  one-cycle pulse when a command's spacing expires
CMD_ERR_out  output  1  sticky; set when a reserved code (111) is accepted

Behaviour:
- Reset (async, any time, including mid-WAIT):
  - CS_N/RAS_N/CAS_N/WE_N = 1 (deselect).
  - BA_out = 0, A_out = 0.
  - CMD_READY_out = 1, CMD_DONE_out = 0, CMD_ERR_out = 0.
  - State = IDLE, counter = 0.
- Accept: CMD_VALID_in & CMD_READY_out at posedge N. Inputs are sampled and registered at edge N.
- State machine:
  - IDLE: CMD_READY_out = 1; pins show NOP (CS_N=0, RAS_N/CAS_N/WE_N=1).
    - Accepting a real command (001–110) -> ISSUE.
    - Accepting 000 or 111 -> stay in IDLE, pins stay NOP, CMD_DONE pulses the next cycle.
    - Accepting 111 also sets CMD_ERR_out.
  - ISSUE (exactly one cycle after edge N): pins carry the command.
    - CS_N=0 plus {RAS_N,CAS_N,WE_N}: LOAD MODE 000, PRECHARGE 010, REFRESH 001, ACTIVATE 011, READ 101, WRITE 100.
    - PRECHARGE ALL forces A_out[10]=1.
    - CMD_READY_out = 0. Counter loads T_x−2. Goes to WAIT at edge N+1.
  - WAIT: pins NOP; BA/A hold their last values. Counter decrements each cycle.
    - When the counter is 0 at an edge: CMD_READY_out rises, CMD_DONE pulses, return to IDLE.
    - Timing: for T_x=2, WAIT lasts 0 extra cycles (ready rises at edge N+1).
- Spacing rule: the next accept is possible no earlier than edge N+T_x, so command-to-command spacing on the pins is exactly T_x cycles.
- CMD_VALID_in while CMD_READY_out=0: ignored. Upstream must hold the command until accepted.
- Back-to-back: when valid is held continuously, commands issue every T_x cycles with no bubble beyond T_x.
- Only the counter and 3-bit code select timing; counter width is clog2(max T)+1.

Test Plan:
- Assert RST_in mid-cycle -> all control pins 1, CMD_READY_out=1, CMD_ERR_out=0 immediately, without waiting for a clock edge.
- Accept PRECHARGE (010), ADDR_in=0 -> next cycle CS/RAS/CAS/WE = 0,0,1,0, A_out[10]=1; CMD_READY_out low for 3 cycles; next accept at edge N+4 (T_RP=4).
- AUTO REFRESH with valid held plus queued ACTIVATE -> ACTIVATE pins appear exactly 26 cycles after REFRESH pins; one CMD_DONE pulse between them.
- LOAD MODE BA_in=2'b01, ADDR_in=13'h0044 -> pins 0,0,0,0, BA_out=01, A_out=0044; ready returns after 1 cycle (T_MRD=2).
- Accept 111 -> pins stay NOP, CMD_ERR_out=1 and remains set after a subsequent valid READ; READ still issues as 0,1,0,1.
- Assert reset during T_WR wait after WRITE -> deselect immediately; after release, a new command is accepted on the first edge.
